risc_processor: RTL and testbench



---
 rtl/risc_pkg.sv | 63 ++++++
 rtl/risc_alu.sv | 40 ++++
 rtl/risc_processor.sv | 148 ++++++++++++++
 tb/tb_risc_processor.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared encodings for the 16-bit RISC core: instruction classes,
// opcodes, branch conditions and instruction field positions.
package risc_pkg;

    localparam logic [1:0] CLS_ALU   = 2'b00;
    localparam logic [1:0] CLS_LDST  = 2'b01;
    localparam logic [1:0] CLS_JUMP  = 2'b10;
    localparam logic [1:0] CLS_NPHLT = 2'b11;

    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_XOR  = 5'b00111;
    localparam logic [4:0] ALU_NAND = 5'b01000;
    localparam logic [4:0] ALU_NOR  = 5'b01001;
    localparam logic [4:0] ALU_NXOR = 5'b01010;
    localparam logic [4:0] ALU_SHR  = 5'b01011;
    localparam logic [4:0] ALU_SHRA = 5'b01100;
    localparam logic [4:0] ALU_SHL  = 5'b01101;

    localparam logic [2:0] LS_LOAD  = 3'b000;
    localparam logic [2:0] LS_LOADC = 3'b001;
    localparam logic [2:0] LS_STORE = 3'b010;

    localparam logic [1:0] J_JMP   = 2'b00;
    localparam logic [1:0] J_JMPR  = 2'b01;
    localparam logic [1:0] J_JMPC  = 2'b10;
    localparam logic [1:0] J_JMPRC = 2'b11;

    localparam logic [2:0] C_N  = 3'b000;
    localparam logic [2:0] C_NN = 3'b001;
    localparam logic [2:0] C_Z  = 3'b010;
    localparam logic [2:0] C_NZ = 3'b011;

    localparam logic [4:0] NP_NOP  = 5'b00000;
    localparam logic [4:0] NP_HALT = 5'b00001;

    localparam int NREGS = 8;

    // Field positions shared by several instruction classes
    localparam int CLS_HI = 15;
    localparam int CLS_LO = 14;
    localparam int OP_HI  = 13;
    localparam int RD_LO  = 6;
    localparam int RA_LO  = 3;
    localparam int OFS_HI = 5;

    function automatic logic cond_met(
        input logic [2:0] cond,
        input logic       neg,
        input logic       zero
    );
        case (cond)
            C_N:     return neg;
            C_NN:    return !neg;
            C_Z:     return zero;
            C_NZ:    return !zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU: op plus two operands to result; valid is low
// for unlisted ops so the caller can suppress the register write.
module risc_alu
    import risc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         valid
);

    localparam int SW = $clog2(W);

    logic [SW-1:0] sh;

    assign sh = b[SW-1:0];

    always_comb begin
        result = '0;
        valid  = 1'b1;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NAND: result = ~(a & b);
            ALU_NOR:  result = ~(a | b);
            ALU_NXOR: result = ~(a ^ b);
            ALU_SHR:  result = a >> sh;
            ALU_SHRA: result = W'($signed(a) >>> sh);
            ALU_SHL:  result = a << sh;
            default:  valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_processor.sv
// Single-cycle 16-bit-instruction / 32-bit-data RISC core with an
// 8x32 register file, load/store, branches and halt.
module risc_processor
    import risc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instruction,
    input  logic [DATA_W-1:0] data_in,
    output logic [PC_W-1:0]   pc,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] rf [NREGS];
    logic              halted;

    logic [1:0]        cls;
    logic [4:0]        alu_op;
    logic [2:0]        rd;
    logic [2:0]        ra;
    logic [2:0]        rb;
    logic [2:0]        ls_op;
    logic [2:0]        ls_r;
    logic [7:0]        imm;
    logic [1:0]        j_op;
    logic [2:0]        j_cond;
    logic [2:0]        j_c;
    logic [2:0]        j_t;
    logic [4:0]        np_op;
    logic [PC_W-1:0]   ofs;

    assign cls    = instruction[CLS_HI:CLS_LO];
    assign alu_op = instruction[OP_HI:9];
    assign rd     = instruction[RD_LO+2:RD_LO];
    assign ra     = instruction[RA_LO+2:RA_LO];
    assign rb     = instruction[2:0];
    assign ls_op  = instruction[OP_HI:11];
    assign ls_r   = instruction[10:8];
    assign imm    = instruction[7:0];
    assign j_op   = instruction[OP_HI:12];
    assign j_cond = instruction[11:9];
    assign j_c    = instruction[RD_LO+2:RD_LO];
    assign j_t    = instruction[2:0];
    assign np_op  = instruction[OP_HI:9];
    assign ofs    = PC_W'($signed(instruction[OFS_HI:0]));

    logic [DATA_W-1:0] alu_res;
    logic              alu_ok;

    risc_alu #(
        .W(DATA_W)
    ) u_alu (
        .op    (alu_op),
        .a     (rf[ra]),
        .b     (rf[rb]),
        .result(alu_res),
        .valid (alu_ok)
    );

    logic [DATA_W-1:0] c_val;
    logic              c_ok;

    assign c_val = rf[j_c];
    assign c_ok  = cond_met(j_cond, c_val[DATA_W-1], c_val == '0);

    logic [PC_W-1:0]   pc_next;
    logic              we;
    logic [2:0]        wsel;
    logic [DATA_W-1:0] wdata;
    logic              halt_req;

    always_comb begin
        pc_next  = pc + 1'b1;
        we       = 1'b0;
        wsel     = rd;
        wdata    = '0;
        halt_req = 1'b0;
        addr     = '0;
        data_out = '0;
        case (cls)
            CLS_ALU: begin
                we    = alu_ok;
                wdata = alu_res;
            end
            CLS_LDST: begin
                wsel = ls_r;
                case (ls_op)
                    LS_LOAD: begin
                        we    = 1'b1;
                        wdata = data_in;
                        addr  = rf[imm[2:0]][ADDR_W-1:0];
                    end
                    LS_LOADC: begin
                        we    = 1'b1;
                        wdata = DATA_W'(imm);
                    end
                    LS_STORE: begin
                        addr     = rf[imm[2:0]][ADDR_W-1:0];
                        data_out = rf[ls_r];
                    end
                    default: ;
                endcase
            end
            CLS_JUMP: begin
                case (j_op)
                    J_JMP:   pc_next = PC_W'(rf[j_t]);
                    J_JMPR:  pc_next = pc + ofs;
                    J_JMPC:  if (c_ok) pc_next = PC_W'(rf[j_t]);
                    J_JMPRC: if (c_ok) pc_next = pc + ofs;
                    default: ;
                endcase
            end
            default: begin
                // HALT holds pc on the halting instruction itself
                if (np_op == NP_HALT) begin
                    halt_req = 1'b1;
                    pc_next  = pc;
                end else if (np_op == NP_NOP) begin
                    pc_next = pc + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= '0;
            halted <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (!halted) begin
            pc <= pc_next;
            if (halt_req) begin
                halted <= 1'b1;
            end
            if (we) begin
                rf[wsel] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_risc_processor.sv
// Directed and randomized bench for risc_processor against a
// behavioural instruction-level model of the core.
module tb_risc_processor;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [31:0] data_in;
    logic [31:0] pc;
    logic [9:0]  addr;
    logic [31:0] data_out;

    risc_processor dut (
        .clk        (clk),
        .reset      (reset),
        .instruction(instruction),
        .data_in    (data_in),
        .pc         (pc),
        .addr       (addr),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    logic [31:0] m_r [8];
    logic [31:0] m_pc;
    bit          m_halt;

    logic [9:0]  obs_addr;
    logic [31:0] obs_dout;

    task automatic check(input string tag,
                         input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] e_alu(input logic [4:0] op,
        input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
        return {2'b00, op, d, a, b};
    endfunction

    function automatic logic [15:0] e_ls(input logic [2:0] op,
        input logic [2:0] r, input logic [7:0] imm);
        return {2'b01, op, r, imm};
    endfunction

    function automatic logic [15:0] e_j(input logic [1:0] op,
        input logic [2:0] cond, input logic [2:0] c, input logic [5:0] lo);
        return {2'b10, op, cond, c, lo};
    endfunction

    localparam logic [15:0] I_NOP  = 16'hC000;
    localparam logic [15:0] I_HALT = 16'hC200;

    // Reference ALU: returns 0 in ok for unlisted ops
    function automatic logic [31:0] m_alu(input logic [4:0] op,
        input logic [31:0] a, input logic [31:0] b, output bit ok);
        int s;
        logic [31:0] v;
        s  = int'(b % 32);
        ok = 1;
        case (op)
            5'd1:  return a + b;
            5'd3:  return a - b;
            5'd5:  return a & b;
            5'd6:  return a | b;
            5'd7:  return a ^ b;
            5'd8:  return ~(a & b);
            5'd9:  return ~(a | b);
            5'd10: return ~(a ^ b);
            5'd11: return a >> s;
            5'd12: begin
                v = a;
                for (int i = 0; i < s; i++) v = {a[31], v[31:1]};
                return v;
            end
            5'd13: return a << s;
            default: begin
                ok = 0;
                return 32'd0;
            end
        endcase
    endfunction

    function automatic bit m_cond(input logic [2:0] cond,
                                  input logic [31:0] v);
        case (cond)
            3'd0: return $signed(v) < 0;
            3'd1: return $signed(v) >= 0;
            3'd2: return v == 0;
            3'd3: return v != 0;
            default: return 0;
        endcase
    endfunction

    task automatic m_outputs(input logic [15:0] ins,
        output logic [9:0] ea, output logic [31:0] ed);
        logic [2:0] op;
        logic [2:0] sel;
        logic [2:0] r;
        logic [31:0] av;
        op  = ins[13:11];
        sel = ins[2:0];
        r   = ins[10:8];
        av  = m_r[sel];
        ea  = 10'd0;
        ed  = 32'd0;
        if (ins[15:14] == 2'b01 && op == 3'd0) ea = av[9:0];
        if (ins[15:14] == 2'b01 && op == 3'd2) begin
            ea = av[9:0];
            ed = m_r[r];
        end
    endtask

    task automatic m_step(input logic [15:0] ins, input logic [31:0] din,
                          input bit rst_n);
        bit ok;
        logic [31:0] res;
        logic [31:0] off;
        logic [31:0] npc;
        logic [1:0]  jop;
        logic [2:0]  lop;
        if (!rst_n) begin
            m_pc   = 0;
            m_halt = 0;
            for (int i = 0; i < 8; i++) m_r[i] = 0;
            return;
        end
        if (m_halt) return;
        npc = m_pc + 1;
        off = 32'($signed(ins[5:0]));
        jop = ins[13:12];
        lop = ins[13:11];
        case (ins[15:14])
            2'b00: begin
                res = m_alu(ins[13:9], m_r[ins[5:3]], m_r[ins[2:0]], ok);
                if (ok) m_r[ins[8:6]] = res;
            end
            2'b01: begin
                if (lop == 3'd0) m_r[ins[10:8]] = din;
                if (lop == 3'd1) m_r[ins[10:8]] = {24'd0, ins[7:0]};
            end
            2'b10: begin
                if (jop == 2'd0) npc = m_r[ins[2:0]];
                if (jop == 2'd1) npc = m_pc + off;
                if (jop == 2'd2 && m_cond(ins[11:9], m_r[ins[8:6]]))
                    npc = m_r[ins[2:0]];
                if (jop == 2'd3 && m_cond(ins[11:9], m_r[ins[8:6]]))
                    npc = m_pc + off;
            end
            default: begin
                if (ins[13:9] == 5'd1) begin
                    m_halt = 1;
                    npc    = m_pc;
                end
            end
        endcase
        m_pc = npc;
    endtask

    task automatic do_step(input logic [15:0] ins, input logic [31:0] din,
                           input bit rst_n);
        logic [9:0]  ea;
        logic [31:0] ed;
        @(negedge clk);
        instruction = ins;
        data_in     = din;
        reset       = rst_n;
        #1;
        m_outputs(ins, ea, ed);
        obs_addr = addr;
        obs_dout = data_out;
        check("addr", {22'd0, addr}, {22'd0, ea});
        check("data_out", data_out, ed);
        @(posedge clk);
        m_step(ins, din, rst_n);
        #1;
        check("pc", pc, m_pc);
    endtask

    task automatic peek(input string tag, input logic [2:0] r,
                        input logic [31:0] exp);
        do_step(e_ls(3'd2, r, 8'd0), 32'd0, 1);
        check(tag, obs_dout, exp);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        instruction = I_NOP;
        data_in     = 32'd0;
        m_pc        = 0;
        m_halt      = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;

        // Reset
        do_step(I_NOP, 32'd0, 0);
        do_step(I_HALT, 32'd0, 0);
        check("reset_pc", pc, 32'd0);
        for (int i = 0; i < 8; i++) peek("reset_reg", 3'(i), 32'd0);
        check("reset_addr", {22'd0, obs_addr}, 32'd0);

        // Load loop
        do_step(e_j(2'd0, 3'd0, 3'd0, 6'd0), 32'd0, 1);
        check("jmp_r0", pc, 32'd0);
        do_step(e_ls(3'd0, 3'd7, 8'd0), 32'd8, 1);
        do_step(e_ls(3'd0, 3'd6, 8'd0), 32'd8, 1);
        do_step(e_ls(3'd0, 3'd5, 8'd0), 32'd8, 1);
        check("load_pc3", pc, 32'd3);
        do_step(e_alu(5'd1, 3'd4, 3'd5, 3'd7), 32'd0, 1);
        do_step(e_alu(5'd3, 3'd2, 3'd6, 3'd7), 32'd0, 1);
        do_step(e_j(2'd0, 3'd0, 3'd0, 6'd2), 32'd0, 1);
        check("loop_pc0", pc, 32'd0);
        peek("add_r4", 3'd4, 32'd16);
        peek("sub_r2", 3'd2, 32'd0);
        peek("load_r5", 3'd5, 32'd8);

        // ALU corner values
        do_step(e_ls(3'd1, 3'd2, 8'd1), 32'd0, 1);
        do_step(e_alu(5'd3, 3'd1, 3'd0, 3'd2), 32'd0, 1);
        do_step(e_alu(5'd1, 3'd3, 3'd1, 3'd2), 32'd0, 1);
        peek("add_wrap", 3'd3, 32'd0);
        do_step(e_alu(5'd12, 3'd3, 3'd1, 3'd2), 32'd0, 1);
        peek("shra", 3'd3, 32'hFFFF_FFFF);
        do_step(e_alu(5'd11, 3'd3, 3'd1, 3'd2), 32'd0, 1);
        peek("shr", 3'd3, 32'h7FFF_FFFF);
        do_step(e_alu(5'd8, 3'd3, 3'd1, 3'd2), 32'd0, 1);
        peek("nand", 3'd3, 32'hFFFF_FFFE);
        do_step(e_alu(5'd31, 3'd3, 3'd1, 3'd2), 32'd0, 1);
        peek("alu_nop", 3'd3, 32'hFFFF_FFFE);

        // pc wrap
        do_step(e_j(2'd0, 3'd0, 3'd0, 6'd1), 32'd0, 1);
        check("pc_max", pc, 32'hFFFF_FFFF);
        do_step(I_NOP, 32'd0, 1);
        check("pc_wrap", pc, 32'd0);

        // Store
        do_step(e_ls(3'd1, 3'd3, 8'h5A), 32'd0, 1);
        do_step(e_ls(3'd1, 3'd1, 8'hFF), 32'd0, 1);
        do_step(e_ls(3'd1, 3'd4, 8'd2), 32'd0, 1);
        do_step(e_alu(5'd13, 3'd1, 3'd1, 3'd4), 32'd0, 1);
        do_step(e_ls(3'd1, 3'd5, 8'd3), 32'd0, 1);
        do_step(e_alu(5'd6, 3'd1, 3'd1, 3'd5), 32'd0, 1);
        do_step(e_ls(3'd2, 3'd3, 8'd1), 32'hDEAD_BEEF, 1);
        check("st_addr", {22'd0, obs_addr}, 32'h3FF);
        check("st_data", obs_dout, 32'h5A);
        peek("st_keep", 3'd3, 32'h5A);

        // Branches
        do_step(e_ls(3'd1, 3'd6, 8'd5), 32'd0, 1);
        do_step(e_j(2'd2, 3'd2, 3'd0, 6'd6), 32'd0, 1);
        check("jmpc_z", pc, 32'd5);
        do_step(e_j(2'd3, 3'd3, 3'd0, 6'h3F), 32'd0, 1);
        check("jmprc_nz", pc, 32'd6);
        do_step(e_ls(3'd1, 3'd6, 8'd4), 32'd0, 1);
        do_step(e_j(2'd0, 3'd0, 3'd0, 6'd6), 32'd0, 1);
        check("jmp_r6", pc, 32'd4);
        do_step(e_j(2'd1, 3'd0, 3'd0, 6'h3E), 32'd0, 1);
        check("jmpr_m2", pc, 32'd2);

        // Halt
        do_step(e_ls(3'd1, 3'd6, 8'd6), 32'd0, 1);
        do_step(e_j(2'd0, 3'd0, 3'd0, 6'd6), 32'd0, 1);
        do_step(I_HALT, 32'd0, 1);
        check("halt_pc", pc, 32'd6);
        for (int i = 0; i < 10; i++) begin
            do_step(e_ls(3'd0, 3'd1, 8'd0), $urandom, 1);
            check("halt_hold", pc, 32'd6);
        end
        peek("halt_regs", 3'd1, 32'h3FF);
        do_step(I_HALT, 32'd0, 0);
        check("halt_reset", pc, 32'd0);
        do_step(I_NOP, 32'd0, 1);
        check("resume", pc, 32'd1);

        // Randomized instruction stream
        for (int n = 0; n < 600; n++) begin
            int k;
            logic [15:0] ins;
            logic [4:0]  ops [11];
            bit          rst_n;
            ops = '{5'd1, 5'd3, 5'd5, 5'd6, 5'd7, 5'd8,
                    5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
            k   = $urandom_range(0, 99);
            ins = 16'($urandom);
            if (k < 40)
                ins = e_alu(ops[$urandom_range(0, 10)], ins[8:6],
                            ins[5:3], ins[2:0]);
            else if (k < 70)
                ins = e_ls(3'($urandom_range(0, 2)), ins[10:8], ins[7:0]);
            else if (k < 85)
                ins = {2'b10, ins[13:12], 2'b00, ins[9:0]};
            else if (k < 88)
                ins = I_HALT;
            rst_n = !(m_halt && $urandom_range(0, 3) == 0);
            do_step(ins, $urandom, rst_n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
